// File: rtl/sprite_renderer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// sprite_renderer : scaled, mirrored, animated sprite lookup (ROM + palette)
// Rev 1.0
// ----------------------------------------------------------------------------
module sprite_renderer #(
   parameter  int SPR_W           = 32,
   parameter  int SPR_H           = 32,
   parameter  int FRAMES          = 4,
   parameter  int SCALE_SHIFT     = 0,
   parameter  int ADDR_W          = 12,
   parameter  int IDX_W           = 4,
   parameter  int TRANSPARENT_IDX = 0,
   parameter  int ANIM_DIV        = 8,
   localparam int FRM_W           = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic              vga_clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              frame_tick,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic [FRM_W-1:0]  frame_sel,
   input  logic              anim_en,
   input  logic              mirror,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [IDX_W-1:0]  pal_index,
   input  logic [3:0]        pal_red,
   input  logic [3:0]        pal_green,
   input  logic [3:0]        pal_blue,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              pix_on
);

   localparam int LXW   = $clog2(SPR_W);
   localparam int LYW   = $clog2(SPR_H);
   localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [10:0] C_SPAN_X = 11'(SPR_W << SCALE_SHIFT);
   localparam logic [10:0] C_SPAN_Y = 11'(SPR_H << SCALE_SHIFT);

   logic [9:0]        sx_q, sx_d, sy_q, sy_d;
   logic              mirror_q, mirror_d;
   logic [FRM_W-1:0]  frame_q, frame_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [ADDR_W-1:0] rom_address_q, rom_address_d;
   logic              v0_q, v1_q;
   logic [3:0]        red_q, green_q, blue_q;
   logic              pix_on_q;

   // Shadow state seen by stage 0; only a frame tick may change it.
   always_comb begin
      sx_d     = sx_q;
      sy_d     = sy_q;
      mirror_d = mirror_q;
      frame_d  = frame_q;
      div_d    = div_q;
      if (frame_tick) begin
         sx_d     = pos_x;
         sy_d     = pos_y;
         mirror_d = mirror;
         if (!anim_en) begin
            frame_d = frame_sel;
         end else if (div_q == DIV_W'(ANIM_DIV - 1)) begin
            div_d   = '0;
            frame_d = (frame_q == FRM_W'(FRAMES - 1)) ? '0 : frame_q + FRM_W'(1);
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

   logic [10:0]       bx, by, sx, sy, dx, dy;
   logic              hit;
   logic [LXW-1:0]    lx_raw, lx;
   logic [LYW-1:0]    ly;
   logic [ADDR_W-1:0] addr;

   // 11-bit edge sums keep a sprite near the right/bottom border from wrapping.
   assign bx     = {1'b0, DrawX};
   assign by     = {1'b0, DrawY};
   assign sx     = {1'b0, sx_q};
   assign sy     = {1'b0, sy_q};
   assign dx     = bx - sx;
   assign dy     = by - sy;
   assign hit    = (bx >= sx) && (bx < sx + C_SPAN_X) &&
                   (by >= sy) && (by < sy + C_SPAN_Y);
   assign lx_raw = LXW'(dx >> SCALE_SHIFT);
   assign ly     = LYW'(dy >> SCALE_SHIFT);
   assign lx     = mirror_q ? (LXW'(SPR_W - 1) - lx_raw) : lx_raw;
   assign addr   = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
                 + ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(lx);
   assign rom_address_d = hit ? addr : rom_address_q;

   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         sx_q          <= '0;
         sy_q          <= '0;
         mirror_q      <= 1'b0;
         frame_q       <= '0;
         div_q         <= '0;
         rom_address_q <= '0;
         v0_q          <= 1'b0;
         v1_q          <= 1'b0;
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
         pix_on_q      <= 1'b0;
      end else begin
         sx_q          <= sx_d;
         sy_q          <= sy_d;
         mirror_q      <= mirror_d;
         frame_q       <= frame_d;
         div_q         <= div_d;
         rom_address_q <= rom_address_d;
         v0_q          <= hit && blank;
         v1_q          <= v0_q;
         if (v1_q && (rom_q != IDX_W'(TRANSPARENT_IDX))) begin
            pix_on_q <= 1'b1;
            red_q    <= pal_red;
            green_q  <= pal_green;
            blue_q   <= pal_blue;
         end else begin
            pix_on_q <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
         end
      end
   end

   assign rom_address = rom_address_q;
   assign pal_index   = rom_q;
   assign red         = red_q;
   assign green       = green_q;
   assign blue        = blue_q;
   assign pix_on      = pix_on_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sprite_renderer : unscaled and 2x instances against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sprite_renderer;

   logic             clk = 1'b0;
   logic             rst;
   logic [9:0]       DrawX, DrawY, pos_x, pos_y;
   logic             blank, frame_tick, anim_en, mirror;
   logic [1:0]       frame_sel;
   logic [1:0][11:0] rom_addr;
   logic [1:0][3:0]  rom_q, pal_idx, pr, pg, pb, red, grn, blu;
   logic [1:0]       pix_on;
   logic [3:0]       rom [4096];

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: shadow registers and the two most recent address/valid stages
   int m_sx, m_sy, m_mir, m_frame, m_div;
   int a_cur[2], a_prev[2];
   bit v_cur[2], v_prev[2];

   always #5 clk = ~clk;

   sprite_renderer #(.SCALE_SHIFT(0)) u_dut0 (
      .vga_clk(clk), .Reset(rst), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .frame_sel(frame_sel),
      .anim_en(anim_en), .mirror(mirror), .rom_address(rom_addr[0]), .rom_q(rom_q[0]),
      .pal_index(pal_idx[0]), .pal_red(pr[0]), .pal_green(pg[0]), .pal_blue(pb[0]),
      .red(red[0]), .green(grn[0]), .blue(blu[0]), .pix_on(pix_on[0])
   );

   sprite_renderer #(.SCALE_SHIFT(1)) u_dut1 (
      .vga_clk(clk), .Reset(rst), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .frame_sel(frame_sel),
      .anim_en(anim_en), .mirror(mirror), .rom_address(rom_addr[1]), .rom_q(rom_q[1]),
      .pal_index(pal_idx[1]), .pal_red(pr[1]), .pal_green(pg[1]), .pal_blue(pb[1]),
      .red(red[1]), .green(grn[1]), .blue(blu[1]), .pix_on(pix_on[1])
   );

   // Synchronous sprite ROM (one-cycle latency) and a combinational palette
   always @(posedge clk) begin
      rom_q[0] <= rom[rom_addr[0]];
      rom_q[1] <= rom[rom_addr[1]];
   end

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         pr[s] = pal_idx[s];
         pg[s] = pal_idx[s] + 4'd3;
         pb[s] = ~pal_idx[s];
      end
   end

   function automatic logic [11:0] pal_rgb(input logic [3:0] i);
      logic [3:0] g;
      g = i + 4'd3;
      return {i, g, ~i};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Where the beam lands on the sprite of instance s (magnification 2^s)
   function automatic void eval(input int s, input int x, input int y,
                                output bit hit, output int addr);
      int span, lx, ly;
      span = 32 << s;
      hit  = (x >= m_sx) && (x < m_sx + span) && (y >= m_sy) && (y < m_sy + span);
      lx   = (x - m_sx) >>> s;
      ly   = (y - m_sy) >>> s;
      if (m_mir != 0) lx = 31 - lx;
      addr = (m_frame * 1024 + ly * 32 + lx) % 4096;
   endfunction

   task automatic model_clear();
      m_sx = 0; m_sy = 0; m_mir = 0; m_frame = 0; m_div = 0;
      for (int s = 0; s < 2; s++) begin
         a_cur[s] = 0; a_prev[s] = 0; v_cur[s] = 0; v_prev[s] = 0;
      end
   endtask

   // One clock with the inputs as currently driven, then compare both instances
   task automatic step();
      bit         e_pix[2];
      logic [11:0] e_rgb[2];
      logic [3:0] e_pidx[2];
      for (int s = 0; s < 2; s++) begin
         bit         h;
         int         a;
         logic [3:0] t;
         eval(s, int'(DrawX), int'(DrawY), h, a);
         t         = rom[a_prev[s]];
         e_pix[s]  = v_prev[s] && (t != 4'd0);
         e_rgb[s]  = e_pix[s] ? pal_rgb(t) : 12'd0;
         e_pidx[s] = rom[a_cur[s]];
         a_prev[s] = a_cur[s];
         v_prev[s] = v_cur[s];
         if (h) a_cur[s] = a;
         v_cur[s] = h && blank;
      end
      if (frame_tick) begin
         m_sx  = int'(pos_x);
         m_sy  = int'(pos_y);
         m_mir = int'(mirror);
         if (!anim_en) begin
            m_frame = int'(frame_sel);
         end else begin
            m_div = m_div + 1;
            if (m_div == 8) begin
               m_div   = 0;
               m_frame = (m_frame + 1) % 4;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check_eq($sformatf("addr%0d", s), 32'(rom_addr[s]), 32'(a_prev[s] == a_cur[s] ? a_cur[s] : a_cur[s]));
         check_eq($sformatf("pix%0d", s), 32'(pix_on[s]), 32'(e_pix[s]));
         check_eq($sformatf("rgb%0d", s), 32'({red[s], grn[s], blu[s]}), 32'(e_rgb[s]));
         check_eq($sformatf("pidx%0d", s), 32'(pal_idx[s]), 32'(e_pidx[s]));
      end
   endtask

   task automatic beam(input int x, input int y, input bit b);
      DrawX = 10'(x);
      DrawY = 10'(y);
      blank = b;
      step();
   endtask

   task automatic tick(input int px, input int py, input int fs, input bit an, input bit mi);
      pos_x = 10'(px); pos_y = 10'(py); frame_sel = 2'(fs);
      anim_en = an; mirror = mi; frame_tick = 1'b1;
      DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      for (int s = 0; s < 2; s++) begin
         check_eq($sformatf("%s_addr%0d", tag, s), 32'(rom_addr[s]), 32'd0);
         check_eq($sformatf("%s_pix%0d", tag, s), 32'(pix_on[s]), 32'd0);
         check_eq($sformatf("%s_rgb%0d", tag, s), 32'({red[s], grn[s], blu[s]}), 32'd0);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("rst");
      #2 rst = 1'b0;
   endtask

   function automatic int clip(input int v);
      return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
   endfunction

   initial begin
      rst = 1'b1;
      DrawX = '0; DrawY = '0; blank = 1'b0; frame_tick = 1'b0;
      pos_x = '0; pos_y = '0; frame_sel = '0; anim_en = 1'b0; mirror = 1'b0;
      for (int i = 0; i < 4096; i++) rom[i] = 4'($urandom_range(0, 15));
      rom[0]    = 4'd0;
      rom[1023] = 4'hA;
      rom[1024] = 4'h7;
      apply_reset();

      // Basic hit, transparency and blanking
      tick(100, 50, 0, 1'b0, 1'b0);
      beam(100, 50, 1'b1);  check_eq("basic_a0", 32'(rom_addr[0]), 32'd0);
      beam(131, 81, 1'b1);  check_eq("basic_a1023", 32'(rom_addr[0]), 32'd1023);
      beam(132, 50, 1'b1);  check_eq("basic_hold", 32'(rom_addr[0]), 32'd1023);
      check_eq("transp_pix", 32'(pix_on[0]), 32'd0);
      beam(200, 200, 1'b0); check_eq("opaque_pix", 32'(pix_on[0]), 32'd1);
      check_eq("opaque_red", 32'(red[0]), 32'hA);
      beam(131, 81, 1'b0);
      beam(200, 200, 1'b0);
      beam(200, 200, 1'b0); check_eq("blank_pix", 32'(pix_on[0]), 32'd0);

      // Mirror
      tick(0, 0, 0, 1'b0, 1'b1);
      beam(0, 0, 1'b1);     check_eq("mirror_a31", 32'(rom_addr[0]), 32'd31);
      beam(31, 0, 1'b1);    check_eq("mirror_a0", 32'(rom_addr[0]), 32'd0);

      // 2x magnification (instance 1)
      tick(10, 10, 0, 1'b0, 1'b0);
      beam(11, 11, 1'b1);   check_eq("scale_a0", 32'(rom_addr[1]), 32'd0);
      beam(12, 10, 1'b1);   check_eq("scale_a1", 32'(rom_addr[1]), 32'd1);
      beam(73, 73, 1'b1);   check_eq("scale_a1023", 32'(rom_addr[1]), 32'd1023);
      beam(74, 10, 1'b1);   check_eq("scale_nohit", 32'(rom_addr[1]), 32'd1023);

      // Animation: eight ticks per frame step, four frames
      repeat (8) tick(10, 10, 0, 1'b1, 1'b0);
      beam(10, 10, 1'b1);   check_eq("anim_f1", 32'(rom_addr[0]), 32'd1024);
      repeat (24) tick(10, 10, 0, 1'b1, 1'b0);
      beam(11, 10, 1'b1);   check_eq("anim_wrap", 32'(rom_addr[0]), 32'd1);

      // Right-edge clipping without wrap-around
      tick(620, 0, 0, 1'b0, 1'b0);
      beam(630, 0, 1'b1);   check_eq("edge_hit", 32'(rom_addr[0]), 32'd10);
      beam(5, 0, 1'b1);     check_eq("edge_nowrap", 32'(rom_addr[0]), 32'd10);
      beam(200, 200, 1'b0);
      beam(200, 200, 1'b0); check_eq("edge_nowrap_pix", 32'(pix_on[0]), 32'd0);

      // Randomised traffic; pos/frame/mirror change every cycle but latch only on ticks
      for (int i = 0; i < 1500; i++) begin
         frame_tick = ($urandom_range(0, 29) == 0);
         pos_x      = 10'($urandom_range(0, 1023));
         pos_y      = 10'($urandom_range(0, 479));
         frame_sel  = 2'($urandom_range(0, 3));
         anim_en    = 1'($urandom_range(0, 1));
         mirror     = 1'($urandom_range(0, 1));
         DrawX      = 10'(clip(m_sx + int'($urandom_range(0, 140)) - 10));
         DrawY      = 10'(clip(m_sy + int'($urandom_range(0, 80)) - 10));
         blank      = ($urandom_range(0, 7) != 0);
         step();
         frame_tick = 1'b0;
      end

      // Reset asserted mid-line clears outputs without waiting for a clock
      rom[5] = 4'h9;
      tick(0, 0, 0, 1'b0, 1'b0);
      beam(5, 0, 1'b1);
      beam(5, 0, 1'b1);
      beam(5, 0, 1'b1);
      #2 rst = 1'b1;
      #1 check_outputs_zero("midrst");
      apply_reset();
      for (int i = 0; i < 4; i++) beam(5 + i, 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
